// File: rtl/datapath_decode_pkg.sv
// Shared decode definitions: widths, opcode set, instruction/ID_EX layouts and source-use table.
package datapath_decode_pkg;

  localparam int IF_ID_WIDTH = 32;
  localparam int ID_EX_WIDTH = 68;
  localparam int NREGS       = 8;
  localparam int RIDX_W      = $clog2(NREGS);

  typedef enum logic [3:0] {
    OP_MV   = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_CMP  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5,
    OP_MVHI = 4'd6,
    OP_JR   = 4'd8,
    OP_JZ   = 4'd9,
    OP_JN   = 4'd10,
    OP_CALL = 4'd12
  } opcode_t;

  // imm8 = {hi, ry}, imm11 = {hi, ry, rx}
  typedef struct packed {
    logic [4:0]        hi;
    logic [RIDX_W-1:0] ry;
    logic [RIDX_W-1:0] rx;
    logic              imm;
    logic [3:0]        opc;
  } instr_fields_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  opc;
  } id_ex_t;

  function automatic logic is_jump(input logic [3:0] opc);
    return opc inside {OP_JR, OP_JZ, OP_JN, OP_CALL};
  endfunction

  function automatic logic uses_rx(input instr_fields_t f);
    return (f.opc inside {OP_ADD, OP_SUB, OP_CMP, OP_ST, OP_MVHI}) || (is_jump(f.opc) && !f.imm);
  endfunction

  function automatic logic uses_ry(input instr_fields_t f);
    return !f.imm && (f.opc inside {OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST});
  endfunction

  function automatic logic [15:0] operand_b(input instr_fields_t f, input logic [15:0] ry_val);
    logic [7:0]  imm8;
    logic [10:0] imm11;
    imm8  = {f.hi, f.ry};
    imm11 = {f.hi, f.ry, f.rx};
    if (f.opc == OP_MVHI)          return {imm8, 8'h00};
    else if (f.imm && is_jump(f.opc)) return {{4{imm11[10]}}, imm11, 1'b0};
    else if (f.imm)                return {{8{imm8[7]}}, imm8};
    else                           return ry_val;
  endfunction

endpackage

// File: rtl/datapath_decode_regfile.sv
// 8x16 register file: two async read ports, one sync write port, write-before-read bypass.
module regfile_8x16
  import datapath_decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [RIDX_W-1:0] ra_addr,
  output logic [15:0]       ra_data,
  input  logic [RIDX_W-1:0] rb_addr,
  output logic [15:0]       rb_data,
  input  logic              wb_en,
  input  logic [RIDX_W-1:0] wb_addr,
  input  logic [15:0]       wb_data
);

  logic [15:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign ra_data = (wb_en && wb_addr == ra_addr) ? wb_data : regs[ra_addr];
  assign rb_data = (wb_en && wb_addr == rb_addr) ? wb_data : regs[rb_addr];

endmodule

// File: rtl/datapath_decode.sv
// Decode/register-read stage, one cycle to ID_EX; a load-use hazard stalls fetch and parks
// the instruction in HOLD, issuing bubbles until the hazard clears; taken squashes everything.
module datapath_decode
  import datapath_decode_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IF_ID_WIDTH-1:0] IF_ID,
  input  logic [15:0]            i_pc_rddata,
  input  logic                   f_valid,
  input  logic                   taken,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic [RIDX_W-1:0]      ex_rd,
  input  logic                   wb_en,
  input  logic [RIDX_W-1:0]      wb_addr,
  input  logic [15:0]            wb_data,
  output logic                   stall,
  output logic [ID_EX_WIDTH-1:0] ID_EX,
  output logic                   d_valid
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [15:0]   hold_instr;
  instr_fields_t cur;
  logic          cur_valid;
  logic          hz;
  logic [15:0]   ra_data;
  logic [15:0]   rb_data;
  id_ex_t        dec;
  logic          unused_if_id;

  assign unused_if_id = ^IF_ID[15:0];

  // imem output is stale while fetch is frozen, so HOLD decodes the parked word
  assign cur       = (state == HOLD) ? hold_instr : i_pc_rddata;
  assign cur_valid = (state == HOLD) | f_valid;

  assign hz = cur_valid & ex_valid & ex_is_load &
              ((ex_rd == cur.rx && uses_rx(cur)) || (ex_rd == cur.ry && uses_ry(cur)));
  assign stall = hz & ~taken;

  regfile_8x16 u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (cur.rx),
    .ra_data (ra_data),
    .rb_addr (cur.ry),
    .rb_data (rb_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  always_comb begin
    dec       = '0;
    dec.pc    = IF_ID[31:16];
    dec.instr = cur;
    dec.op_a  = ra_data;
    dec.op_b  = operand_b(cur, rb_data);
    dec.opc   = cur.opc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      hold_instr <= '0;
      ID_EX      <= '0;
      d_valid    <= 1'b0;
    end else if (taken) begin
      state      <= RUN;
      hold_instr <= '0;
      ID_EX      <= '0;
      d_valid    <= 1'b0;
    end else if (stall) begin
      if (state == RUN) hold_instr <= i_pc_rddata;
      state   <= HOLD;
      ID_EX   <= '0;
      d_valid <= 1'b0;
    end else begin
      state   <= RUN;
      ID_EX   <= cur_valid ? dec : '0;
      d_valid <= cur_valid;
    end
  end

endmodule

// File: tb/tb_datapath_decode.sv
// Scenario tests plus a randomized run against a queue-based reference of the decode stage.
module tb_datapath_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_ID;
  logic [15:0] i_pc_rddata;
  logic        f_valid, taken, ex_valid, ex_is_load;
  logic [2:0]  ex_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall;
  logic [67:0] ID_EX;
  logic        d_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mregs [8];

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) for (int i = 0; i < 8; i++) mregs[i] <= 16'h0;
    else if (wb_en) mregs[wb_addr] <= wb_data;
  end

  datapath_decode dut (
    .clk(clk), .reset(reset), .IF_ID(IF_ID), .i_pc_rddata(i_pc_rddata),
    .f_valid(f_valid), .taken(taken), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .ID_EX(ID_EX), .d_valid(d_valid)
  );

  function automatic logic [15:0] rf(input logic [2:0] a);
    return (wb_en && wb_addr == a) ? wb_data : mregs[a];
  endfunction

  function automatic logic [67:0] ref_dec(input logic [15:0] ins, input logic [15:0] pc);
    logic [15:0] b;
    int opc;
    opc = int'(ins[3:0]);
    if (opc == 6)                                   b = {ins[15:8], 8'h00};
    else if (ins[4] && (opc inside {8, 9, 10, 12})) b = {{4{ins[15]}}, ins[15:5], 1'b0};
    else if (ins[4])                                b = {{8{ins[15]}}, ins[15:8]};
    else                                            b = rf(ins[10:8]);
    return {pc, ins, rf(ins[7:5]), b, ins[3:0]};
  endfunction

  function automatic bit ref_hz(input logic [15:0] ins, input bit live);
    int opc;
    bit imm, rx_u, ry_u;
    opc  = int'(ins[3:0]);
    imm  = ins[4];
    rx_u = (opc inside {1, 2, 3, 5, 6}) || ((opc inside {8, 9, 10, 12}) && !imm);
    ry_u = !imm && (opc inside {[0:5]});
    return live && ex_valid && ex_is_load &&
           ((rx_u && ex_rd == ins[7:5]) || (ry_u && ex_rd == ins[10:8]));
  endfunction

  task automatic drive_idle();
    IF_ID = 32'h0; i_pc_rddata = 16'h0; f_valid = 0; taken = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 3'd0; wb_en = 0; wb_addr = 3'd0; wb_data = 16'h0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ID_EX !== 68'h0) begin n_bad++; $display("FAIL reset_id_ex: got %h want 0", ID_EX); end
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL reset_d_valid: got %b want 0", d_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    reset = 1'b1;
    IF_ID = {16'h0002, 16'h0}; i_pc_rddata = 16'h0530; f_valid = 1;
    @(negedge clk);
    n_cmp++; if (ID_EX[3:0] !== 4'h0) begin n_bad++; $display("FAIL mv_opc: got %h want 0", ID_EX[3:0]); end
    n_cmp++; if (ID_EX[19:4] !== 16'h0005) begin n_bad++; $display("FAIL mv_opb: got %h want 0005", ID_EX[19:4]); end
    n_cmp++; if (ID_EX[67:52] !== 16'h0002) begin n_bad++; $display("FAIL mv_pc: got %h want 0002", ID_EX[67:52]); end
    n_cmp++; if (d_valid !== 1'b1) begin n_bad++; $display("FAIL mv_d_valid: got %b want 1", d_valid); end
  endtask

  task automatic test_preload();
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      wb_en = 1; wb_addr = 3'(i); wb_data = 16'($urandom);
      @(negedge clk);
      n_cmp++; if (d_valid !== 1'b0 || ID_EX !== 68'h0) begin
        n_bad++; $display("FAIL idle_bubble: got v=%b id_ex=%h want v=0 id_ex=0", d_valid, ID_EX);
      end
    end
    wb_en = 0;
  endtask

  task automatic test_bypass();
    logic [67:0] exp_id;
    drive_idle();
    wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    i_pc_rddata = 16'h0361; f_valid = 1; IF_ID = {16'h0010, 16'h0};
    #1 exp_id = ref_dec(i_pc_rddata, 16'h0010);
    @(negedge clk);
    n_cmp++; if (ID_EX[35:20] !== 16'hBEEF) begin n_bad++; $display("FAIL bypass_opa: got %h want beef", ID_EX[35:20]); end
    n_cmp++; if (ID_EX[19:4] !== 16'hBEEF) begin n_bad++; $display("FAIL bypass_opb: got %h want beef", ID_EX[19:4]); end
    n_cmp++; if (ID_EX !== exp_id) begin n_bad++; $display("FAIL bypass_id_ex: got %h want %h", ID_EX, exp_id); end
    wb_en = 0;
    @(negedge clk);
    n_cmp++; if (ID_EX[35:20] !== 16'hBEEF || ID_EX[19:4] !== 16'hBEEF) begin
      n_bad++; $display("FAIL stored_r3: got a=%h b=%h want beef", ID_EX[35:20], ID_EX[19:4]);
    end
  endtask

  task automatic test_load_use();
    logic [67:0] exp_id;
    drive_idle();
    ex_valid = 1; ex_is_load = 1; ex_rd = 3'd2;
    i_pc_rddata = 16'h0221; f_valid = 1; IF_ID = {16'h0020, 16'h0};
    #1 exp_id = ref_dec(16'h0221, 16'h0020);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall); end
    @(negedge clk);
    n_cmp++; if (ID_EX !== 68'h0 || d_valid !== 1'b0) begin
      n_bad++; $display("FAIL lu_bubble: got v=%b id_ex=%h want v=0 id_ex=0", d_valid, ID_EX);
    end
    i_pc_rddata = 16'($urandom); ex_valid = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_release_stall: got %b want 0", stall); end
    @(negedge clk);
    n_cmp++; if (ID_EX !== exp_id || d_valid !== 1'b1) begin
      n_bad++; $display("FAIL lu_issue: got v=%b id_ex=%h want v=1 id_ex=%h", d_valid, ID_EX, exp_id);
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] exp_id;
    drive_idle();
    ex_valid = 1; ex_is_load = 1; ex_rd = 3'd1;
    i_pc_rddata = 16'h0422; f_valid = 1; IF_ID = {16'h0030, 16'h0};
    #1 exp_id = ref_dec(16'h0422, 16'h0030);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall%0d: got %b want 1", k, stall); end
      @(negedge clk);
      n_cmp++; if (ID_EX !== 68'h0 || d_valid !== 1'b0) begin
        n_bad++; $display("FAIL b2b_bubble%0d: got v=%b id_ex=%h want v=0 id_ex=0", k, d_valid, ID_EX);
      end
      i_pc_rddata = 16'($urandom);
      #1;
    end
    ex_valid = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_release_stall: got %b want 0", stall); end
    @(negedge clk);
    n_cmp++; if (ID_EX !== exp_id || d_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_issue: got v=%b id_ex=%h want v=1 id_ex=%h", d_valid, ID_EX, exp_id);
    end
    f_valid = 0;
    @(negedge clk);
    n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_single_issue: got v=%b want 0", d_valid); end
  endtask

  task automatic test_taken_hold();
    logic [67:0] exp_id;
    drive_idle();
    ex_valid = 1; ex_is_load = 1; ex_rd = 3'd6;
    i_pc_rddata = 16'h06A3; f_valid = 1; IF_ID = {16'h0038, 16'h0};
    @(negedge clk);
    taken = 1; i_pc_rddata = 16'($urandom);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL th_stall: got %b want 0", stall); end
    @(negedge clk);
    n_cmp++; if (ID_EX !== 68'h0 || d_valid !== 1'b0) begin
      n_bad++; $display("FAIL th_squash: got v=%b id_ex=%h want v=0 id_ex=0", d_valid, ID_EX);
    end
    taken = 0; ex_valid = 0; i_pc_rddata = 16'h7F46; IF_ID = {16'h0040, 16'h0};
    #1 exp_id = ref_dec(16'h7F46, 16'h0040);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL th_run_stall: got %b want 0", stall); end
    @(negedge clk);
    n_cmp++; if (ID_EX !== exp_id || d_valid !== 1'b1) begin
      n_bad++; $display("FAIL th_resume: got v=%b id_ex=%h want v=1 id_ex=%h", d_valid, ID_EX, exp_id);
    end
    n_cmp++; if (ID_EX[19:4] !== 16'h7F00) begin n_bad++; $display("FAIL mvhi_opb: got %h want 7f00", ID_EX[19:4]); end
  endtask

  task automatic test_taken_nohz();
    logic [67:0] exp_id;
    drive_idle();
    taken = 1; f_valid = 1; i_pc_rddata = 16'hFFF9; IF_ID = {16'h0050, 16'h0};
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL tn_stall: got %b want 0", stall); end
    @(negedge clk);
    n_cmp++; if (ID_EX !== 68'h0 || d_valid !== 1'b0) begin
      n_bad++; $display("FAIL tn_squash: got v=%b id_ex=%h want v=0 id_ex=0", d_valid, ID_EX);
    end
    taken = 0;
    #1 exp_id = ref_dec(16'hFFF9, 16'h0050);
    @(negedge clk);
    n_cmp++; if (ID_EX !== exp_id || d_valid !== 1'b1) begin
      n_bad++; $display("FAIL tn_resume: got v=%b id_ex=%h want v=1 id_ex=%h", d_valid, ID_EX, exp_id);
    end
    n_cmp++; if (ID_EX[19:4] !== 16'hFFFE) begin n_bad++; $display("FAIL jz_imm11: got %h want fffe", ID_EX[19:4]); end
  endtask

  task automatic test_random();
    logic [15:0] held [$];
    logic [15:0] cur;
    logic [67:0] exp_id;
    bit exp_v, live, hz, have_exp;
    have_exp = 0; exp_id = '0; exp_v = 0;
    for (int c = 0; c <= 400; c++) begin
      @(negedge clk);
      if (have_exp) begin
        n_cmp++; if (ID_EX !== exp_id || d_valid !== exp_v) begin
          n_bad++; $display("FAIL rand_out@%0d: got v=%b id_ex=%h want v=%b id_ex=%h", c, d_valid, ID_EX, exp_v, exp_id);
        end
      end
      if (c == 400) break;
      taken = ($urandom_range(0, 7) == 0);
      ex_valid = 1'($urandom); ex_is_load = 1'($urandom); ex_rd = 3'($urandom);
      wb_en = 1'($urandom); wb_addr = 3'($urandom); wb_data = 16'($urandom);
      i_pc_rddata = 16'($urandom); f_valid = ($urandom_range(0, 3) != 0);
      if (held.size() == 0) IF_ID = $urandom;
      #1;
      live = (held.size() != 0) || f_valid;
      cur  = (held.size() != 0) ? held[0] : i_pc_rddata;
      hz   = ref_hz(cur, live);
      n_cmp++; if (stall !== (hz && !taken)) begin
        n_bad++; $display("FAIL rand_stall@%0d: got %b want %b", c, stall, hz && !taken);
      end
      if (taken) begin
        exp_id = '0; exp_v = 0; held.delete();
      end else if (hz) begin
        exp_id = '0; exp_v = 0;
        if (held.size() == 0) held.push_back(cur);
      end else begin
        exp_v  = live;
        exp_id = live ? ref_dec(cur, IF_ID[31:16]) : '0;
        if (held.size() != 0) void'(held.pop_front());
      end
      have_exp = 1;
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_bypass();
    test_load_use();
    test_back_to_back();
    test_taken_hold();
    test_taken_nohz();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
